// File: rtl/prio_enc_pipe.sv
// Registered N-input priority encoder with a valid/ready handshake on both sides.
// The winner is either the highest set index (fixed) or found by a round-robin search from a rotating pointer.
module prio_enc_pipe #(
  parameter int N       = 8,
  parameter int RR_MODE = 0,
  localparam int W      = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_req,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_index,
  output logic         out_none,
  output logic         out_multi,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] ptr;
  logic [W-1:0] shamt;
  logic [N-1:0] rot;
  logic [W-1:0] rot_index;
  logic [W-1:0] enc_index;
  logic         enc_none;
  logic         enc_multi;
  logic         capture;

  function automatic logic [W-1:0] highest_set(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  // Rotate so that request[ptr] lands in the top bit; a plain highest-set search then
  // walks ptr, ptr-1, ... with wraparound, and adding shamt back undoes the rotation.
  always_comb begin
    shamt = ptr + W'(1);
    rot   = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = in_req[W'(i) + shamt];
    end
    rot_index = highest_set(rot);
    if (RR_MODE != 0) begin
      enc_index = rot_index + shamt;
    end else begin
      enc_index = highest_set(in_req);
    end
    enc_none  = ~|in_req;
    enc_multi = |(in_req & (in_req - N'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_none  <= 1'b0;
      out_multi <= 1'b0;
      ptr       <= '1;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_index <= enc_none ? '0 : enc_index;
      out_none  <= enc_none;
      out_multi <= enc_multi;
      // The winner drops to lowest priority; empty captures leave the pointer alone.
      if (!enc_none) ptr <= enc_index - W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
